// File: rtl/fetch_pc_predictor_r0_pkg.sv
// Shared definitions for the fetch PC predictor: 2-bit counter encodings,
// PC increment and the saturating counter update rule.
package fetch_pc_predictor_r0_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam int unsigned PC_INCR   = 4;
  localparam ctr_t        CTR_ALLOC = CTR_WT;

  // Saturating step toward the resolved outcome; the strong states hold.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken && (c != CTR_ST)) begin
      n = ctr_t'(2'(c + 2'd1));
    end else if (!taken && (c != CTR_SNT)) begin
      n = ctr_t'(2'(c - 2'd1));
    end
    return n;
  endfunction

endpackage

// File: rtl/fetch_pc_predictor_r0_btb.sv
// Direct-mapped BTB storage: one lookup read port, one training write port.
// Only valid bits are reset; tag/target/counter contents are gated by valid.
module btb_table_r0
  import fetch_pc_predictor_r0_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IDX_W-1:0]              rd_idx,
  input  logic [BIT_WIDTH-2-IDX_W-1:0]  rd_tag,
  output logic                          rd_taken,
  output logic [BIT_WIDTH-1:0]          rd_target,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [BIT_WIDTH-2-IDX_W-1:0]  wr_tag,
  input  logic                          wr_taken,
  input  logic [BIT_WIDTH-1:0]          wr_target
);

  localparam int unsigned TAG_W   = BIT_WIDTH - 2 - IDX_W;
  localparam int unsigned ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0]   r_valid;
  logic [TAG_W-1:0]     r_tag    [ENTRIES];
  logic [BIT_WIDTH-1:0] r_target [ENTRIES];
  ctr_t                 r_ctr    [ENTRIES];

  logic w_rd_hit;
  logic w_wr_hit;

  assign w_rd_hit  = r_valid[rd_idx] && (r_tag[rd_idx] == rd_tag);
  assign rd_taken  = w_rd_hit && r_ctr[rd_idx][1];
  assign rd_target = r_target[rd_idx];
  assign w_wr_hit  = r_valid[wr_idx] && (r_tag[wr_idx] == wr_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (wr_en && !w_wr_hit && wr_taken) begin
      r_valid[wr_idx] <= 1'b1;
    end
  end

  // Hit trains the counter; a taken miss allocates over whatever is there.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (w_wr_hit) begin
        r_ctr[wr_idx] <= ctr_next(r_ctr[wr_idx], wr_taken);
        if (wr_taken) begin
          r_target[wr_idx] <= wr_target;
        end
      end else if (wr_taken) begin
        r_tag[wr_idx]    <= wr_tag;
        r_target[wr_idx] <= wr_target;
        r_ctr[wr_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_predictor_r0.sv
// IF-stage PC register with BTB-based next-PC prediction, EX-stage
// mispredict detection/redirect and a saturating mispredict counter.
module fetch_pc_predictor_r0
  import fetch_pc_predictor_r0_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH       = 32,
  parameter int unsigned          BTB_INDEX_WIDTH = 4,
  parameter logic [BIT_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PC_write,
  output logic [BIT_WIDTH-1:0] if_pc,
  output logic                 if_pred_taken,
  output logic [BIT_WIDTH-1:0] if_pred_target,
  input  logic                 ex_branch,
  input  logic [BIT_WIDTH-1:0] ex_pc,
  input  logic                 ex_taken,
  input  logic [BIT_WIDTH-1:0] ex_target,
  input  logic [BIT_WIDTH-1:0] ex_pred_next,
  output logic                 mispredict,
  output logic [15:0]          mispredict_count
);

  localparam int unsigned TAG_WIDTH = BIT_WIDTH - 2 - BTB_INDEX_WIDTH;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  logic [BIT_WIDTH-1:0] r_pc;
  logic [15:0]          r_count;
  logic                 w_btb_taken;
  logic [BIT_WIDTH-1:0] w_btb_target;
  logic [BIT_WIDTH-1:0] w_pc_seq;
  logic [BIT_WIDTH-1:0] w_actual_next;
  logic [BIT_WIDTH-1:0] w_pc_next;

  btb_table_r0 #(
    .BIT_WIDTH (BIT_WIDTH),
    .IDX_W     (BTB_INDEX_WIDTH)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst),
    .rd_idx    (r_pc[BTB_INDEX_WIDTH+1:2]),
    .rd_tag    (r_pc[BIT_WIDTH-1:BTB_INDEX_WIDTH+2]),
    .rd_taken  (w_btb_taken),
    .rd_target (w_btb_target),
    .wr_en     (ex_branch),
    .wr_idx    (ex_pc[BTB_INDEX_WIDTH+1:2]),
    .wr_tag    (ex_pc[BIT_WIDTH-1:BTB_INDEX_WIDTH+2]),
    .wr_taken  (ex_taken),
    .wr_target (ex_target)
  );

  assign w_pc_seq       = r_pc + BIT_WIDTH'(PC_INCR);
  assign if_pc          = r_pc;
  assign if_pred_taken  = w_btb_taken;
  assign if_pred_target = w_btb_taken ? w_btb_target : w_pc_seq;

  assign w_actual_next    = ex_taken ? ex_target : (ex_pc + BIT_WIDTH'(PC_INCR));
  assign mispredict       = ex_branch && (w_actual_next != ex_pred_next);
  assign mispredict_count = r_count;

  // Redirect beats a stall: the instruction held in ID is on the wrong path.
  always_comb begin
    w_pc_next = r_pc;
    if (mispredict) begin
      w_pc_next = w_actual_next;
    end else if (PC_write) begin
      w_pc_next = if_pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_count <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (mispredict && (r_count != CNT_MAX)) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  logic [TAG_WIDTH-1:0] w_unused_tag_width;
  assign w_unused_tag_width = '0;

endmodule
